pmt_threshold_trigger: RTL and testbench

Single-bin threshold trigger that sits directly downstream of the fake-signal injection stage. It consumes the packed ADC words for PMT channels 0-2 (HG in [23:12], LG in [11:0]). For each channel it tracks a slow baseline on the HG sample and compares the baseline-subtracted amplitude against a programmable threshold. It raises a one-cycle TRIGGER when enough channels coincide, then applies a holdoff and re-arm sequence.

---
 rtl/pmt_threshold_trigger.sv | 176 +++++++++++++++++
 tb/tb_pmt_threshold_trigger.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_threshold_trigger.sv
// pmt_threshold_trigger
// Single-bin coincidence trigger for PMT channels 0-2. Each channel's HG
// sample is compared against a slowly tracked baseline plus a threshold.
// When enough channels are above threshold together, one TRIGGER pulse is
// issued. The FSM then holds off for a fixed time and re-arms once all
// channels have dropped back below threshold.
module pmt_threshold_trigger #(
  parameter int HOLDOFF_CYCLES = 64,
  parameter int BASE_INIT      = 200,
  parameter int BASE_FRAC      = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [11:0] THRESH,
  input  logic [1:0]  MULT,
  input  logic [23:0] ADC0_IN,
  input  logic [23:0] ADC1_IN,
  input  logic [23:0] ADC2_IN,
  output logic        TRIGGER,
  output logic [2:0]  TRIG_MASK,
  output logic [15:0] TRIG_COUNT,
  output logic [11:0] BASE0,
  output logic [11:0] BASE1,
  output logic [11:0] BASE2,
  output logic        ACTIVE
);

  localparam int ACC_W = 12 + BASE_FRAC;
  localparam logic [ACC_W-1:0] ACC_INIT  = ACC_W'(BASE_INIT << BASE_FRAC);
  localparam logic [11:0]      BASE_RST  = 12'(BASE_INIT);
  localparam logic [15:0]      HOLD_LOAD = 16'(HOLDOFF_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, TRIG, HOLDOFF, REARM} state_t;

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  mask_q, mask_d;
  logic [15:0] count_q, count_d;

  logic [2:0]  above_q, above_d;
  logic [11:0] adc_hg [3];
  logic [11:0] base_w [3];
  logic        track_en;
  logic [1:0]  nabove;
  logic        coinc;

  // The LG halves of the packed words carry no information for this trigger.
  logic unused_lg;
  assign unused_lg = ^{ADC0_IN[11:0], ADC1_IN[11:0], ADC2_IN[11:0]};

  assign adc_hg[0] = ADC0_IN[23:12];
  assign adc_hg[1] = ADC1_IN[23:12];
  assign adc_hg[2] = ADC2_IN[23:12];

  // Baselines only follow the signal while the trigger is idle, so pulses
  // and their tails do not pull the pedestal estimate upward.
  assign track_en = (state_q == IDLE);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : gen_ch
      logic [11:0]       hg_q;
      logic [ACC_W-1:0]  acc_q, acc_d;
      logic [11:0]       base_q;
      logic [ACC_W-1:0]  hg_ext;
      logic signed [12:0] amp;

      assign hg_ext = {hg_q, {BASE_FRAC{1'b0}}};

      // Signed excursion above baseline; negative values never exceed THRESH.
      assign amp         = $signed({1'b0, hg_q}) - $signed({1'b0, base_q});
      assign above_d[gi] = (amp > $signed({1'b0, THRESH}));
      assign base_w[gi]  = base_q;

      // One fractional LSB step toward the current sample, saturating at both ends.
      always_comb begin
        acc_d = acc_q;
        if (track_en && !above_q[gi]) begin
          if ((hg_ext > acc_q) && (acc_q != '1)) begin
            acc_d = acc_q + ACC_W'(1);
          end else if ((hg_ext < acc_q) && (acc_q != '0)) begin
            acc_d = acc_q - ACC_W'(1);
          end
        end
      end

      // Sample capture, baseline accumulator and its registered integer part.
      always_ff @(posedge CLK) begin
        if (RESET) begin
          hg_q   <= '0;
          acc_q  <= ACC_INIT;
          base_q <= BASE_RST;
        end else begin
          hg_q   <= adc_hg[gi];
          acc_q  <= acc_d;
          base_q <= acc_d[ACC_W-1:BASE_FRAC];
        end
      end
    end
  endgenerate

  // Per-channel above-threshold flags for the coincidence stage.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      above_q <= '0;
    end else begin
      above_q <= above_d;
    end
  end

  assign nabove = {1'b0, above_q[0]} + {1'b0, above_q[1]} + {1'b0, above_q[2]};
  assign coinc  = (MULT != 2'd0) && (nabove >= MULT);

  // Trigger sequencer: next state, holdoff counter, mask capture and trigger count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (ENABLE && coinc) begin
          state_d = TRIG;
          mask_d  = above_q;
          count_d = count_q + 16'd1;
        end
      end
      TRIG: begin
        state_d = HOLDOFF;
        cnt_d   = HOLD_LOAD;
      end
      HOLDOFF: begin
        if (cnt_q == 16'd0) begin
          state_d = REARM;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      REARM: begin
        if (above_q == 3'b000) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping ENABLE abandons any sequence in progress but keeps the history.
    if (!ENABLE && (state_q != IDLE)) begin
      state_d = IDLE;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      count_q <= count_d;
    end
  end

  assign TRIGGER    = (state_q == TRIG);
  assign ACTIVE     = (state_q != IDLE);
  assign TRIG_MASK  = mask_q;
  assign TRIG_COUNT = count_q;
  assign BASE0      = base_w[0];
  assign BASE1      = base_w[1];
  assign BASE2      = base_w[2];

endmodule

// File: tb/tb_pmt_threshold_trigger.sv
// Directed bench for pmt_threshold_trigger: reset, coincidence, threshold
// edges, holdoff spacing, ENABLE/RESET aborts and baseline drift.
module tb_pmt_threshold_trigger;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [11:0] THRESH;
  logic [1:0]  MULT;
  logic [23:0] ADC0_IN, ADC1_IN, ADC2_IN;
  logic        TRIGGER;
  logic [2:0]  TRIG_MASK;
  logic [15:0] TRIG_COUNT;
  logic [11:0] BASE0, BASE1, BASE2;
  logic        ACTIVE;

  int n_cmp = 0;
  int n_err = 0;
  logic [11:0] base_lvl = 12'd200;

  pmt_threshold_trigger #(.HOLDOFF_CYCLES(64), .BASE_INIT(200), .BASE_FRAC(4)) dut (
    .CLK(CLK), .RESET(RESET), .ENABLE(ENABLE), .THRESH(THRESH), .MULT(MULT),
    .ADC0_IN(ADC0_IN), .ADC1_IN(ADC1_IN), .ADC2_IN(ADC2_IN),
    .TRIGGER(TRIGGER), .TRIG_MASK(TRIG_MASK), .TRIG_COUNT(TRIG_COUNT),
    .BASE0(BASE0), .BASE1(BASE1), .BASE2(BASE2), .ACTIVE(ACTIVE)
  );

  always #5 CLK = ~CLK;

  function automatic logic [23:0] pk(input logic [11:0] hg);
    return {hg, 12'hA5C};
  endfunction

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a pulse of height amp on the channels in chm for width cycles
  // (optionally repeated at start2), counting TRIGGER cycles seen.
  task automatic run_pulse(input logic [2:0] chm, input logic [11:0] amp,
                           input int width, input int start2, input int total,
                           output int ntrig, output int first);
    logic on;
    ntrig = 0;
    first = -1;
    for (int i = 0; i < total; i++) begin
      on = (i < width) || ((start2 >= 0) && (i >= start2) && (i < start2 + width));
      ADC0_IN = pk((on && chm[0]) ? amp : base_lvl);
      ADC1_IN = pk((on && chm[1]) ? amp : base_lvl);
      ADC2_IN = pk((on && chm[2]) ? amp : base_lvl);
      tick();
      if (TRIGGER === 1'b1) begin
        ntrig++;
        if (first < 0) first = i;
      end
    end
  endtask

  task automatic hold_level(input logic [11:0] lvl, input int cycles, inout int mono_bad, input bit rising);
    logic [11:0] prev;
    ADC0_IN = pk(lvl);
    ADC1_IN = pk(lvl);
    ADC2_IN = pk(lvl);
    prev = BASE0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (rising ? (BASE0 < prev) : (BASE0 > prev)) mono_bad++;
      prev = BASE0;
    end
  endtask

  initial begin
    int nt, fi, mono_bad;

    // Reset with arbitrary inputs
    RESET = 1'b1; ENABLE = 1'b1; THRESH = 12'd5; MULT = 2'd1;
    ADC0_IN = 24'hFFFFFF; ADC1_IN = 24'h123456; ADC2_IN = 24'h800800;
    tick(); tick();
    chk("rst_base0", 32'(BASE0), 200);
    chk("rst_base1", 32'(BASE1), 200);
    chk("rst_base2", 32'(BASE2), 200);
    chk("rst_trigger", 32'(TRIGGER), 0);
    chk("rst_count", 32'(TRIG_COUNT), 0);
    chk("rst_active", 32'(ACTIVE), 0);
    chk("rst_mask", 32'(TRIG_MASK), 0);
    $display("reset: base=%0d/%0d/%0d count=%0d", BASE0, BASE1, BASE2, TRIG_COUNT);

    ADC0_IN = pk(12'd200); ADC1_IN = pk(12'd200); ADC2_IN = pk(12'd200);
    RESET = 1'b0; THRESH = 12'd100; MULT = 2'd2;
    for (int i = 0; i < 8; i++) tick();

    // 30-cycle pulse on all channels
    run_pulse(3'b111, 12'd2047, 30, -1, 120, nt, fi);
    $display("wide pulse: ntrig=%0d first=%0d mask=%b count=%0d", nt, fi, TRIG_MASK, TRIG_COUNT);
    chk("wide_ntrig", 32'(nt), 1);
    chk("wide_latency", 32'(fi), 2);
    chk("wide_mask", 32'(TRIG_MASK), 3'b111);
    chk("wide_count", 32'(TRIG_COUNT), 1);
    chk("wide_base0", 32'(BASE0), 200);
    chk("wide_base1", 32'(BASE1), 200);
    chk("wide_base2", 32'(BASE2), 200);
    chk("wide_idle", 32'(ACTIVE), 0);

    // Single-channel pulse against the three MULT settings
    run_pulse(3'b001, 12'd2047, 4, -1, 80, nt, fi);
    $display("ch0 mult=2: ntrig=%0d", nt);
    chk("ch0_m2_ntrig", 32'(nt), 0);
    MULT = 2'd1;
    run_pulse(3'b001, 12'd2047, 4, -1, 80, nt, fi);
    $display("ch0 mult=1: ntrig=%0d first=%0d mask=%b", nt, fi, TRIG_MASK);
    chk("ch0_m1_ntrig", 32'(nt), 1);
    chk("ch0_m1_latency", 32'(fi), 2);
    chk("ch0_m1_mask", 32'(TRIG_MASK), 3'b001);
    chk("ch0_m1_count", 32'(TRIG_COUNT), 2);
    MULT = 2'd0;
    run_pulse(3'b001, 12'd2047, 4, -1, 80, nt, fi);
    $display("ch0 mult=0: ntrig=%0d", nt);
    chk("ch0_m0_ntrig", 32'(nt), 0);
    chk("ch0_m0_count", 32'(TRIG_COUNT), 2);

    // Threshold edge: amplitude exactly THRESH does not count, THRESH+1 does
    MULT = 2'd1;
    run_pulse(3'b001, 12'd300, 4, -1, 80, nt, fi);
    $display("amp=100 thr=100: ntrig=%0d", nt);
    chk("thr_eq_ntrig", 32'(nt), 0);
    run_pulse(3'b001, 12'd301, 4, -1, 80, nt, fi);
    $display("amp=101 thr=100: ntrig=%0d", nt);
    chk("thr_gt_ntrig", 32'(nt), 1);
    chk("thr_gt_count", 32'(TRIG_COUNT), 3);

    // THRESH=0: flat input is silent, a 1-count excursion triggers
    THRESH = 12'd0;
    run_pulse(3'b001, 12'd200, 4, -1, 80, nt, fi);
    $display("thr=0 flat: ntrig=%0d", nt);
    chk("thr0_flat_ntrig", 32'(nt), 0);
    run_pulse(3'b001, 12'd201, 4, -1, 80, nt, fi);
    $display("thr=0 amp=1: ntrig=%0d", nt);
    chk("thr0_pos_ntrig", 32'(nt), 1);
    chk("thr0_pos_count", 32'(TRIG_COUNT), 4);

    // Below-baseline samples never count; stop before the baseline recovers
    run_pulse(3'b001, 12'd0, 4, -1, 6, nt, fi);
    $display("negative amp: ntrig=%0d", nt);
    chk("neg_ntrig", 32'(nt), 0);
    ENABLE = 1'b0; THRESH = 12'd100;
    for (int i = 0; i < 60; i++) tick();
    chk("neg_base0_recovered", 32'(BASE0), 200);
    chk("neg_idle", 32'(ACTIVE), 0);
    chk("neg_count", 32'(TRIG_COUNT), 4);
    ENABLE = 1'b1; MULT = 2'd2;

    // Holdoff spacing
    run_pulse(3'b111, 12'd2047, 4, 40, 140, nt, fi);
    $display("spacing 40: ntrig=%0d count=%0d", nt, TRIG_COUNT);
    chk("sp40_ntrig", 32'(nt), 1);
    chk("sp40_count", 32'(TRIG_COUNT), 5);
    run_pulse(3'b111, 12'd2047, 4, 100, 200, nt, fi);
    $display("spacing 100: ntrig=%0d count=%0d", nt, TRIG_COUNT);
    chk("sp100_ntrig", 32'(nt), 2);
    chk("sp100_count", 32'(TRIG_COUNT), 7);

    // ENABLE drop during holdoff
    run_pulse(3'b111, 12'd2047, 4, -1, 10, nt, fi);
    chk("en_active", 32'(ACTIVE), 1);
    ENABLE = 1'b0;
    tick();
    $display("enable drop: active=%0d count=%0d mask=%b", ACTIVE, TRIG_COUNT, TRIG_MASK);
    chk("en_drop_idle", 32'(ACTIVE), 0);
    chk("en_drop_count", 32'(TRIG_COUNT), 8);
    chk("en_drop_mask", 32'(TRIG_MASK), 3'b111);
    ENABLE = 1'b1;
    for (int i = 0; i < 10; i++) tick();

    // RESET during holdoff, then a pulse right after release
    run_pulse(3'b111, 12'd2047, 4, -1, 20, nt, fi);
    chk("rh_active", 32'(ACTIVE), 1);
    chk("rh_count", 32'(TRIG_COUNT), 9);
    RESET = 1'b1;
    tick();
    $display("reset in holdoff: active=%0d count=%0d", ACTIVE, TRIG_COUNT);
    chk("rh_idle", 32'(ACTIVE), 0);
    chk("rh_count_clr", 32'(TRIG_COUNT), 0);
    chk("rh_mask_clr", 32'(TRIG_MASK), 0);
    RESET = 1'b0;
    run_pulse(3'b111, 12'd2047, 4, -1, 80, nt, fi);
    $display("post-reset pulse: ntrig=%0d first=%0d count=%0d", nt, fi, TRIG_COUNT);
    chk("pr_ntrig", 32'(nt), 1);
    chk("pr_latency", 32'(fi), 2);
    chk("pr_count", 32'(TRIG_COUNT), 1);

    // Baseline drift up to 216 and down to 190
    mono_bad = 0;
    hold_level(12'd216, 200, mono_bad, 1'b1);
    $display("drift up 200 cyc: base0=%0d", BASE0);
    chk("up_mid_base0", 32'(BASE0), 212);
    hold_level(12'd216, 100, mono_bad, 1'b1);
    $display("drift up 300 cyc: base=%0d/%0d/%0d", BASE0, BASE1, BASE2);
    chk("up_base0", 32'(BASE0), 216);
    chk("up_base1", 32'(BASE1), 216);
    chk("up_base2", 32'(BASE2), 216);
    hold_level(12'd216, 50, mono_bad, 1'b1);
    chk("up_hold_base0", 32'(BASE0), 216);
    chk("up_monotonic", 32'(mono_bad), 0);
    mono_bad = 0;
    hold_level(12'd190, 380, mono_bad, 1'b0);
    $display("drift down 380 cyc: base0=%0d", BASE0);
    chk("dn_mid_base0", 32'(BASE0), 192);
    hold_level(12'd190, 70, mono_bad, 1'b0);
    $display("drift down 450 cyc: base=%0d/%0d/%0d", BASE0, BASE1, BASE2);
    chk("dn_base0", 32'(BASE0), 190);
    chk("dn_base1", 32'(BASE1), 190);
    chk("dn_base2", 32'(BASE2), 190);
    chk("dn_monotonic", 32'(mono_bad), 0);
    chk("drift_count", 32'(TRIG_COUNT), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
